memory_burst_master: RTL and testbench



---
 rtl/memory_burst_pkg.sv | 13 +
 rtl/burst_addr_counter.sv | 36 +++
 rtl/memory_burst_master.sv | 141 ++++++++++++++
 tb/tb_memory_burst_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_burst_pkg.sv
// Shared state and command-op encodings for the memory burst master.
package memory_burst_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/burst_addr_counter.sv
// Burst address/remaining-count tracker: loads on command accept, steps once per beat.
module burst_addr_counter
  import memory_burst_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 6,
  parameter int LEN_WIDTH         = ADDRESS_BUS_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_load,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_load_addr,
  input  logic [LEN_WIDTH-1:0]         i_load_len,
  input  logic                         i_step,
  output logic [ADDRESS_BUS_WIDTH-1:0] o_addr,
  output logic                         o_last
);
  logic [ADDRESS_BUS_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]         r_rem;

  // Address wraps naturally modulo the memory depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_load_addr;
      r_rem  <= i_load_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDRESS_BUS_WIDTH'(1);
      r_rem  <= r_rem - LEN_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == LEN_WIDTH'(1));
endmodule

// File: rtl/memory_burst_master.sv
// Burst initiator for the single-port word memory. Optional macro
// MEMORY_BURST_RANGE_CHECK_EN adds an err output and rejects out-of-range bursts.
module memory_burst_master
  import memory_burst_pkg::*;
#(
  parameter int BITS              = 64,
  parameter int ADDRESS_BUS_WIDTH = 6,
  parameter int LEN_WIDTH         = ADDRESS_BUS_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic [BITS-1:0]              wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [BITS-1:0]              rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic                         done,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [BITS-1:0]              mem_d,
  output logic                         mem_we,
  input  logic [BITS-1:0]              mem_q
`ifdef MEMORY_BURST_RANGE_CHECK_EN
  ,
  output logic                         err
`endif
);
  state_t                       r_state, w_next;
  logic                         w_load, w_step, w_last, w_capture, w_range_err;
  logic [ADDRESS_BUS_WIDTH-1:0] w_addr;
  logic                         r_rd_valid;
  logic [BITS-1:0]              r_rd_data;

  burst_addr_counter #(
    .ADDRESS_BUS_WIDTH(ADDRESS_BUS_WIDTH),
    .LEN_WIDTH        (LEN_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_addr(cmd_addr),
    .i_load_len (cmd_len),
    .i_step     (w_step),
    .o_addr     (w_addr),
    .o_last     (w_last)
  );

`ifdef MEMORY_BURST_RANGE_CHECK_EN
  localparam int SW = ADDRESS_BUS_WIDTH + 2;
  localparam logic [SW-1:0] DEPTH = SW'(1) << ADDRESS_BUS_WIDTH;
  logic [SW-1:0] w_end;
  logic          r_err;

  assign w_end       = SW'(cmd_addr) + SW'(cmd_len);
  assign w_range_err = (w_end > DEPTH);

  always_ff @(posedge clk) begin
    if (reset)       r_err <= 1'b0;
    else if (w_load) r_err <= w_range_err;
  end

  assign err = (r_state == ST_DONE) && r_err && !reset;
`else
  assign w_range_err = 1'b0;
`endif

  // A new word is fetched whenever the output register is empty or being drained.
  assign w_capture = (r_state == ST_READ) && (!r_rd_valid || rd_ready);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_d       = '0;
    mem_address = '0;
    done        = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_load = 1'b1;
          if (cmd_len == '0 || w_range_err) w_next = ST_DONE;
          else if (cmd_write == OP_WRITE)   w_next = ST_WRITE;
          else                              w_next = ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready    = 1'b1;
        mem_d       = wr_data;
        mem_we      = wr_valid;
        mem_address = w_addr;
        w_step      = wr_valid;
        if (wr_valid && w_last) w_next = ST_DONE;
      end
      ST_READ: begin
        mem_address = w_addr;
        w_step      = w_capture;
        if (w_capture && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (rd_ready) w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Nothing may reach the memory or the done line while reset is held.
    if (reset) begin
      mem_we = 1'b0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_capture) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= mem_q;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
endmodule

// File: tb/tb_memory_burst_master.sv
// Randomized bench for memory_burst_master with an attached word memory and a reference memory model.
module tb_memory_burst_master;
  localparam int AW   = 6;
  localparam int BITS = 64;
  localparam int LW   = AW + 1;
  localparam int DEP  = 1 << AW;
`ifdef MEMORY_BURST_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [LW-1:0]   cmd_len = '0;
  logic [BITS-1:0] wr_data = '0;
  logic            wr_valid = 1'b0, wr_ready;
  logic [BITS-1:0] rd_data;
  logic            rd_valid, rd_ready = 1'b0, done;
  logic [AW-1:0]   mem_address;
  logic [BITS-1:0] mem_d, mem_q;
  logic            mem_we;
`ifdef MEMORY_BURST_RANGE_CHECK_EN
  logic            err;
`endif

  logic [BITS-1:0] mem    [DEP];
  logic [BITS-1:0] refmem [DEP];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_burst_master #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .mem_address(mem_address), .mem_d(mem_d), .mem_we(mem_we),
    .mem_q(mem_q)
`ifdef MEMORY_BURST_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  // Attached single-port memory: combinational read, write on rising edge.
  assign mem_q = mem[mem_address];
  always @(posedge clk) if (mem_we) mem[mem_address] <= mem_d;

  function automatic logic [BITS-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Runs one burst against the reference memory. base!=0 gives data base+i; stall_beat>=0
  // holds rd_ready low for two cycles while that beat index is presented.
  task automatic do_burst(input bit wr, input int addr, input int len, input int p_stall,
                          input int stall_beat, input logic [BITS-1:0] base, input string nm);
    logic [BITS-1:0] wq[$];
    logic [AW-1:0]   ea[$];
    logic [BITS-1:0] prev_data = '0;
    bit prev_hold = 1'b0, rerr;
    int got_w = 0, got_r = 0, cyc = 0, first_cyc = 0, done_cyc = 0, done_cnt = 0;
    int bad_rdy = 0, bad_ord = 0, bad_stab = 0, bad_err = 0, stall_left = 2, exp_done, mm = 0;
    rerr = RC && (addr + len > DEP);
    for (int i = 0; i < len; i++) begin
      wq.push_back(base != '0 ? base + BITS'(i) : rand64());
      ea.push_back(AW'((addr + i) % DEP));
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(addr); cmd_len = LW'(len);
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s cmd_ready_idle: got %b want 1", nm, cmd_ready);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      wr_valid = (got_w < len) && ($urandom_range(99) >= p_stall);
      wr_data  = (got_w < len) ? wq[got_w] : rand64();
      if (stall_beat >= 0 && got_r == stall_beat && rd_valid && stall_left > 0) begin
        rd_ready = 1'b0; stall_left--;
      end else rd_ready = ($urandom_range(99) >= p_stall);
      #1;
      if (cmd_ready) bad_rdy++;
      if ((wr_ready || rd_valid) && first_cyc == 0) first_cyc = cyc;
      if (prev_hold && (!rd_valid || rd_data !== prev_data)) bad_stab++;
      if (wr_valid && wr_ready) begin
        if (!mem_we || got_w >= len) bad_ord++;
        else if (mem_address !== ea[got_w] || mem_d !== wq[got_w]) bad_ord++;
        got_w++;
      end else if (mem_we) bad_ord++;
      if (rd_valid && rd_ready) begin
        if (got_r >= len) bad_ord++;
        else if (rd_data !== refmem[ea[got_r]]) bad_ord++;
        got_r++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
`ifdef MEMORY_BURST_RANGE_CHECK_EN
      if (err !== (done && rerr)) bad_err++;
`endif
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    vectors++;
    if (done_cnt != 1) begin
      miscompares++; $display("FAIL %s done_seen: got %0d want 1 (timeout)", nm, done_cnt);
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s after_done: done=%b cmd_ready=%b want 0/1", nm, done, cmd_ready);
    end
    vectors++;
    if (got_w != ((wr && !rerr) ? len : 0) || got_r != ((!wr && !rerr) ? len : 0)) begin
      miscompares++;
      $display("FAIL %s beat_count: writes=%0d reads=%0d want %0d", nm, got_w, got_r, rerr ? 0 : len);
    end
    vectors++;
    if (bad_ord != 0) begin
      miscompares++; $display("FAIL %s beat_content: got %0d bad beats want 0", nm, bad_ord);
    end
    vectors++;
    if (bad_stab != 0 || bad_rdy != 0 || bad_err != 0) begin
      miscompares++;
      $display("FAIL %s protocol: unstable=%0d cmd_ready_busy=%0d err_bad=%0d want 0", nm, bad_stab, bad_rdy, bad_err);
    end
    vectors++;
    if (first_cyc != ((len == 0 || rerr) ? 0 : (wr ? 1 : 2))) begin
      miscompares++; $display("FAIL %s first_beat_latency: got %0d want %0d", nm, first_cyc,
                              (len == 0 || rerr) ? 0 : (wr ? 1 : 2));
    end
    exp_done = (len == 0 || rerr) ? 1 : (wr ? len + 1 : len + 2);
    if ((p_stall == 0 && stall_beat < 0) || len == 0 || rerr) begin
      vectors++;
      if (done_cyc != exp_done) begin
        miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc, exp_done);
      end
    end
    if (wr && !rerr) for (int i = 0; i < len; i++) refmem[ea[i]] = wq[i];
    for (int i = 0; i < DEP; i++) if (mem[i] !== refmem[i]) mm++;
    vectors++;
    if (mm != 0) begin
      miscompares++; $display("FAIL %s mem_contents: got %0d differing words want 0", nm, mm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({cmd_ready, wr_ready, rd_valid, done, mem_we} !== 5'b10000 || mem_address !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy/wrdy/rv/done/we=%b addr=%0d rd=%h want 10000/0/0",
               {cmd_ready, wr_ready, rd_valid, done, mem_we}, mem_address, rd_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_basic();
    do_burst(1'b1, 4, 3, 0, -1, 64'hA, "write_basic");
    vectors++;
    if (mem[4] !== 64'hA || mem[5] !== 64'hB || mem[6] !== 64'hC) begin
      miscompares++; $display("FAIL write_basic_readback: got %h %h %h want a b c", mem[4], mem[5], mem[6]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [BITS-1:0] d0, d1;
    int seen = 0;
    d0 = rand64(); d1 = rand64();
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20; cmd_len = 5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); wr_valid = 1'b1; wr_data = d0; #1;
    vectors++;
    if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rst_mid_first_we: got %b want 1", mem_we); end
    @(negedge clk); wr_data = d1;
    @(negedge clk); reset = 1'b1; wr_data = rand64(); #1;
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mid_we_gated: got %b want 0", mem_we); end
    @(negedge clk); reset = 1'b0; #1;
    vectors++;
    if ({mem_we, cmd_ready, wr_ready, done} !== 4'b0100) begin
      miscompares++; $display("FAIL rst_mid_idle: we/rdy/wrdy/done=%b want 0100", {mem_we, cmd_ready, wr_ready, done});
    end
    wr_valid = 1'b0;
    repeat (6) begin @(negedge clk); #1 if (done) seen++; end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); end
    vectors++;
    if (mem[20] !== d0 || mem[21] !== d1 || mem[22] !== refmem[22]) begin
      miscompares++; $display("FAIL rst_mid_persist: got %h %h %h want %h %h %h",
                              mem[20], mem[21], mem[22], d0, d1, refmem[22]);
    end
    refmem[20] = d0; refmem[21] = d1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++)
      do_burst(1'(($urandom_range(1))), $urandom_range(DEP - 1),
               ($urandom_range(3) == 0) ? 0 : $urandom_range(DEP), $urandom_range(50), -1, '0, "random");
  endtask

  initial begin
    test_reset();
    do_burst(1'b1, 0, DEP, 0, -1, '0, "fill_full");
    test_write_basic();
    do_burst(1'b0, 4, 3, 0, 1, '0, "read_stall");
    do_burst(1'b1, 62, 4, 0, -1, '0, "write_wrap");
    do_burst(1'b0, 62, 4, 0, -1, '0, "read_wrap");
    do_burst(1'b1, 7, 0, 0, -1, '0, "zero_len_wr");
    do_burst(1'b0, 7, 0, 0, -1, '0, "zero_len_rd");
    test_reset_mid_write();
    do_burst(1'b0, 0, DEP, 40, -1, '0, "full_read");
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
